sync_fifo_p: RTL and testbench
==============================

Name: sync_fifo_p

Overview:
Parametrised single-clock FIFO. Successor to the team's fixed 8x8 FIFO, adding:
- generic width and depth
- occupancy count
- almost-full and almost-empty thresholds
- overflow/underflow error pulses
- a selectable first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer in the same clock domain, e.g. behind a UART receiver or ahead of a packet parser.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 16: number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr, input, 1: write request.
- rd, input, 1: read request.
- data_in, input, WIDTH: write data.
- data_out, output, WIDTH: read data.
- empty, output, 1: FIFO holds 0 entries.
- full, output, 1: FIFO holds DEPTH entries.
- almost_full, output, 1: count >= AF_THRESH.
- almost_empty, output, 1: count <= AE_THRESH.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: one-cycle pulse, write was rejected.
- underflow, output, 1: one-cycle pulse, read was rejected.

Behaviour:
- Clocking and reset: single clock domain (clk); asynchronous active-low reset (reset_n).
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, ADDR_W = $clog2(DEPTH).
  - Storage is indexed by the low ADDR_W bits; the MSB is the wrap bit.
  - Pointers wrap naturally modulo 2*DEPTH.
- count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Flags are combinational decodes of the registered pointers only, never of wr/rd:
  - empty = (count == 0)
  - full = (count == DEPTH)
  - almost_full = (count >= AF_THRESH)
  - almost_empty = (count <= AE_THRESH)
- Read acceptance: rd_acc = rd && !empty.
- Write acceptance: wr_acc = wr && (!full || rd_acc).
  - When full, a simultaneous read and write are both accepted; count is unchanged.
  - When empty, a simultaneous read and write: write accepted, read rejected; count goes 0 -> 1.
- Pointer updates: on wr_acc, mem[wr_ptr] <= data_in and wr_ptr increments. On rd_acc, rd_ptr increments.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at the same edge. Data is valid the cycle after rd is sampled (latency 1).
  - data_out holds its value otherwise, including on rejected reads.
  - Full + read + write: the old head is read before the slot is rewritten.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever !empty; forced to 0 when empty.
  - rd acts as acknowledge/pop; the next entry appears the cycle after rd_acc.
  - Write-to-visible latency is 1 cycle: the word written at edge N is on data_out after edge N when the FIFO was empty.
- overflow: registered pulse, high for exactly one cycle after an edge where wr && !wr_acc.
- underflow: registered pulse, high for exactly one cycle after an edge where rd && !rd_acc.
- Both error pulses may be high in the same cycle. Rejected requests never change state.
- Reset values, applied asynchronously at any time including mid-transfer:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1
  - almost_full = 0 (since AF_THRESH >= 1)
  - overflow = 0, underflow = 0
  - data_out = 0 in both modes
- Storage array is not reset. Contents are undefined after reset and are never observable until rewritten.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD=0, FIFO_FWFT=1}, used to document the FWFT parameter.
  - Helper function addr_w(depth) returning $clog2(depth).
- Sub-module fifo_mem_p (WIDTH, DEPTH): one synchronous write port and one asynchronous read port, no reset.
- sync_fifo_p owns pointers, flags, error pulses and mode muxing.
- Elaboration-time checks reject a non-power-of-two DEPTH or out-of-range thresholds.

Test Plan:
Bench configuration is WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless noted.
1. Fill/drain, FWFT=0: after reset write 0x10..0x17 over 8 cycles -> full=1, count=8, almost_full from count=6. Then read 8 cycles -> data_out 0x10..0x17, each one cycle after rd; empty=1 at end.
2. Overflow/underflow: on full, a 9th write of 0xAA -> overflow pulses 1 cycle, count stays 8, 0xAA never read. On empty, a read -> underflow pulses 1 cycle, data_out unchanged.
3. Simultaneous ops: full + rd&wr of 0x55 -> count stays 8, data_out = oldest entry, 0x55 read last. Empty + rd&wr of 0x66 -> count=1, underflow pulses.
4. Wrap-around: 20 interleaved single write/read pairs with data 0..19 -> pointers cross the wrap bit twice; data order preserved; empty never falsely asserts full.
5. FWFT=1: write 0x3C to empty FIFO -> data_out=0x3C the next cycle with no rd. Pulse rd -> data_out shows the next entry, or 0 if now empty.
6. Reset mid-operation: with count=5, drop reset_n asynchronously between edges -> count=0, empty=1, data_out=0 immediately. After release, the first write/read returns the new data, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_p.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_p
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_p.sv
// Single-clock FIFO with occupancy count, threshold flags, error pulses and
// selectable standard / first-word-fall-through read mode.
module sync_fifo_p
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned FWFT      = int'(FIFO_STD),
    localparam int unsigned AW       = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AfC    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AeC    = (AW + 1)'(AE_THRESH);

    if (WIDTH < 1) begin : gen_bad_width
        $error("sync_fifo_p: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("sync_fifo_p: DEPTH must be a power of two, at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : gen_bad_af
        $error("sync_fifo_p: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : gen_bad_ae
        $error("sync_fifo_p: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT > 1) begin : gen_bad_mode
        $error("sync_fifo_p: FWFT must be 0 or 1");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Flags decode the registered pointers only, never the live requests.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (count == '0);
    assign full         = (count == DepthC);
    assign almost_full  = (count >= AfC);
    assign almost_empty = (count <= AeC);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_acc      = rd && !empty;
        wr_acc      = wr && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = wr && !wr_acc;
        underflow_d = rd && !rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT == int'(FIFO_FWFT)) begin : gen_fwft
        // Head word is always presented; zero while nothing valid is stored.
        assign data_out = empty ? '0 : mem_rdata;
    end else begin : gen_std
        logic [WIDTH-1:0] dout_q, dout_d;

        // Async read of the current head, so a full read+write sees the old word.
        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = mem_rdata;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed bench: standard and FWFT instances driven by the same request stream.
module tb_sync_fifo_p;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr, rd;
    logic [7:0] din;

    logic [7:0] s_dout, f_dout;
    logic       s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
    logic       f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] s_count, f_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_p #(
        .WIDTH     (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1),
        .FWFT      (0)
    ) u_std (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .data_in      (din),
        .data_out     (s_dout),
        .empty        (s_empty),
        .full         (s_full),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .count        (s_count),
        .overflow     (s_ovf),
        .underflow    (s_udf)
    );

    sync_fifo_p #(
        .WIDTH     (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1),
        .FWFT      (1)
    ) u_fwft (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .rd           (rd),
        .data_in      (din),
        .data_out     (f_dout),
        .empty        (f_empty),
        .full         (f_full),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 8; i++) begin
            wr  = 1'b1;
            din = 8'(base + i);
            step();
            check("fill_count", 32'(s_count), 32'(i + 1));
            check("fill_af", 32'(s_af), 32'((i + 1) >= 6));
            check("fill_full", 32'(s_full), 32'((i + 1) == 8));
            check("fill_fwft_head", 32'(f_dout), 32'(base));
        end
        wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        din     = 8'h00;
        #12;
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_af", 32'(s_af), 0);
        check("rst_ovf", 32'(s_ovf), 0);
        check("rst_udf", 32'(s_udf), 0);
        check("rst_dout_std", 32'(s_dout), 0);
        check("rst_dout_fwft", 32'(f_dout), 0);
        check("rst_fwft_empty", 32'(f_empty), 1);
        reset_n = 1'b1;
        step();

        // Fill, overflow, drain, underflow.
        fill(8'h10);
        wr  = 1'b1;
        din = 8'hAA;
        step();
        wr  = 1'b0;
        check("ovf_pulse", 32'(s_ovf), 1);
        check("ovf_count", 32'(s_count), 8);
        check("ovf_fwft_pulse", 32'(f_ovf), 1);
        step();
        check("ovf_one_cycle", 32'(s_ovf), 0);
        for (int i = 0; i < 8; i++) begin
            check("drain_fwft_pre", 32'(f_dout), 32'(8'h10 + i));
            rd = 1'b1;
            step();
            check("drain_std_dout", 32'(s_dout), 32'(8'h10 + i));
            check("drain_count", 32'(s_count), 32'(7 - i));
            check("drain_fwft_post", 32'(f_dout), (i < 7) ? 32'(8'h11 + i) : 32'd0);
        end
        rd = 1'b0;
        check("drain_empty", 32'(s_empty), 1);
        check("drain_ae", 32'(s_ae), 1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("udf_pulse", 32'(s_udf), 1);
        check("udf_dout_hold", 32'(s_dout), 32'h17);
        check("udf_count", 32'(s_count), 0);
        step();
        check("udf_one_cycle", 32'(s_udf), 0);

        // Simultaneous read and write while full, then while empty.
        fill(8'h20);
        wr  = 1'b1;
        rd  = 1'b1;
        din = 8'h55;
        step();
        wr  = 1'b0;
        check("full_rw_dout", 32'(s_dout), 32'h20);
        check("full_rw_count", 32'(s_count), 8);
        check("full_rw_ovf", 32'(s_ovf), 0);
        check("full_rw_fwft", 32'(f_dout), 32'h21);
        for (int i = 0; i < 8; i++) begin
            step();
            check("full_rw_order", 32'(s_dout), (i < 7) ? 32'(8'h21 + i) : 32'h55);
        end
        rd = 1'b0;
        check("full_rw_empty", 32'(s_empty), 1);
        wr  = 1'b1;
        rd  = 1'b1;
        din = 8'h66;
        step();
        wr = 1'b0;
        rd = 1'b0;
        check("empty_rw_count", 32'(s_count), 1);
        check("empty_rw_udf", 32'(s_udf), 1);
        check("empty_rw_dout", 32'(s_dout), 32'h55);
        check("empty_rw_fwft", 32'(f_dout), 32'h66);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("empty_rw_read", 32'(s_dout), 32'h66);

        // Wrap-around with single write/read pairs.
        for (int i = 0; i < 20; i++) begin
            wr  = 1'b1;
            din = 8'(i);
            step();
            wr = 1'b0;
            check("wrap_fwft", 32'(f_dout), 32'(i));
            check("wrap_count", 32'(s_count), 1);
            rd = 1'b1;
            step();
            rd = 1'b0;
            check("wrap_dout", 32'(s_dout), 32'(i));
            check("wrap_empty", 32'(s_empty), 1);
            check("wrap_full", 32'(s_full), 0);
        end

        // Asynchronous reset with five entries held.
        for (int i = 0; i < 5; i++) begin
            wr  = 1'b1;
            din = 8'(8'h30 + i);
            step();
        end
        wr = 1'b0;
        check("pre_rst_count", 32'(s_count), 5);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(s_count), 0);
        check("arst_empty", 32'(s_empty), 1);
        check("arst_dout_std", 32'(s_dout), 0);
        check("arst_dout_fwft", 32'(f_dout), 0);
        check("arst_fwft_count", 32'(f_count), 0);
        step();
        step();
        reset_n = 1'b1;
        wr  = 1'b1;
        din = 8'h77;
        step();
        wr = 1'b0;
        check("post_rst_count", 32'(s_count), 1);
        check("post_rst_fwft", 32'(f_dout), 32'h77);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("post_rst_dout", 32'(s_dout), 32'h77);
        check("post_rst_empty", 32'(s_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
